div_unit: RTL and testbench



---
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish one edge after start.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LastStep = 6'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      count_q, count_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] origDividend_q, origDividend_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negQuot_q, negQuot_d;
  logic            negRem_q, negRem_d;
  logic            opRem_q, opRem_d;
  logic            divZero_q, divZero_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  logic            signedOp, dividendNeg, divisorNeg;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] quoFinal, remFinal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      divisor_q      <= '0;
      origDividend_q <= '0;
      result_q       <= '0;
      negQuot_q      <= 1'b0;
      negRem_q       <= 1'b0;
      opRem_q        <= 1'b0;
      divZero_q      <= 1'b0;
      overflow_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      quo_q          <= quo_d;
      rem_q          <= rem_d;
      divisor_q      <= divisor_d;
      origDividend_q <= origDividend_d;
      result_q       <= result_d;
      negQuot_q      <= negQuot_d;
      negRem_q       <= negRem_d;
      opRem_q        <= opRem_d;
      divZero_q      <= divZero_d;
      overflow_q     <= overflow_d;
      done_q         <= done_d;
    end
  end

  // Magnitudes are divided unsigned; signs are restored on the final edge.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    divisor_d      = divisor_q;
    origDividend_d = origDividend_q;
    result_d       = result_q;
    negQuot_d      = negQuot_q;
    negRem_d       = negRem_q;
    opRem_d        = opRem_q;
    divZero_d      = divZero_q;
    overflow_d     = overflow_q;
    done_d         = 1'b0;

    signedOp    = ~op[0];
    dividendNeg = signedOp & dividend[XLEN-1];
    divisorNeg  = signedOp & divisor[XLEN-1];
    shifted     = {rem_q, quo_q[XLEN-1]};
    quoFinal    = negQuot_q ? -quo_q : quo_q;
    remFinal    = negRem_q ? -rem_q : rem_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !flush) begin
          state_d        = CALC;
          count_d        = '0;
          rem_d          = '0;
          quo_d          = dividendNeg ? -dividend : dividend;
          divisor_d      = divisorNeg ? -divisor : divisor;
          origDividend_d = dividend;
          negQuot_d      = dividendNeg ^ divisorNeg;
          negRem_d       = dividendNeg;
          opRem_d        = op[1];
          divZero_d      = (divisor == '0);
          overflow_d     = signedOp && (dividend == MinNeg) && (divisor == '1);
`ifdef DIV_FAST_SPECIAL_EN
          if ((divisor == '0) || (signedOp && (dividend == MinNeg) && (divisor == '1)))
            count_d = LastStep;
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == LastStep) begin
          // Special cases override whatever the datapath accumulated.
          if (divZero_q) begin
            quoFinal = '1;
            remFinal = origDividend_q;
          end else if (overflow_q) begin
            quoFinal = MinNeg;
            remFinal = '0;
          end
          result_d = opRem_q ? remFinal : quoFinal;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          count_d = count_q + 6'd1;
          if (shifted >= {1'b0, divisor_q}) begin
            rem_d = shifted[XLEN-1:0] - divisor_q;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == CALC);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operations against an arithmetic model.
// Latency expectations follow the DIV_FAST_SPECIAL_EN macro when it is defined for the build.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FastSpecial = 1'b1;
`else
  localparam bit FastSpecial = 1'b0;
`endif

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int refLatency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (FastSpecial && special) ? 1 : 33;
  endfunction

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res);
    lat      = 0;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", {31'b0, busy}, 32'd1);
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) begin
        @(posedge clk);
        @(negedge clk);
      end else if (done) begin
        lat = n;
        break;
      end
      if (n > 1 && done) begin
        lat = n;
        break;
      end
      if (n == 1) begin
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          lat = 1;
          break;
        end
      end
    end
    res = result;
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] res;
    applyStimulus(o, a, b, lat, res);
    checkOutput({tag, " result"}, res, refResult(o, a, b));
    checkOutput({tag, " latency"}, 32'(lat), 32'(refLatency(o, a, b)));
    checkOutput({tag, " busy in done cycle"}, {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          sawDone;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst = 1'b0;

    // flush wins over start while idle
    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("idle flush drops start", {31'b0, busy}, 32'd0);

    runOp("DIVU 100/7", 2'b01, 32'd100, 32'd7);
    runOp("REMU 100/7 back-to-back", 2'b11, 32'd100, 32'd7);
    @(negedge clk);
    checkOutput("done single pulse", {31'b0, done}, 32'd0);
    checkOutput("result holds", result, 32'd2);

    runOp("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    runOp("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    runOp("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE);
    runOp("DIVU 5/0", 2'b01, 32'd5, 32'd0);
    runOp("REMU 5/0", 2'b11, 32'd5, 32'd0);
    runOp("DIV 5/0", 2'b00, 32'd5, 32'd0);
    runOp("REM -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    runOp("DIV overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("REM overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // second start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("busy after E%0d", e), {31'b0, busy}, (e < 33) ? 32'd1 : 32'd0);
      if (e == 4) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else if (e == 5) begin
        start = 1'b0;
      end
    end
    checkOutput("ignored start done", {31'b0, done}, 32'd1);
    checkOutput("ignored start result", result, 32'd10);

    // flush mid-calculation
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sawDone = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
      if (e == 9) flush = 1'b1;
      if (e == 10) begin
        flush = 1'b0;
        checkOutput("busy after flush", {31'b0, busy}, 32'd0);
      end
    end
    checkOutput("no done after flush", {31'b0, sawDone}, 32'd0);
    checkOutput("result kept after flush", result, 32'd10);
    runOp("DIVU 9/3 after flush", 2'b01, 32'd9, 32'd3);

    // synchronous reset mid-calculation
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sawDone = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) sawDone = 1'b1;
      if (e == 11) rst = 1'b1;
      if (e == 12) begin
        rst = 1'b0;
        checkOutput("busy after mid reset", {31'b0, busy}, 32'd0);
        checkOutput("done after mid reset", {31'b0, done}, 32'd0);
        checkOutput("result after mid reset", result, 32'd0);
      end
    end
    checkOutput("no done after mid reset", {31'b0, sawDone}, 32'd0);
    runOp("DIVU 1000/10 after reset", 2'b01, 32'd1000, 32'd10);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pickOperand();
      rb = pickOperand();
      runOp($sformatf("rand%0d op%0d 0x%08h/0x%08h", i, ro, ra, rb), ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
